// File: rtl/mmio_bus_controller.sv
// Table-driven MMIO decoder with registered request/ack handshake toward slaves,
// wait-state support, and sticky bus-error status for unmapped or timed-out accesses.
//
// state  | meaning
// IDLE   | waiting for MemRead/MemWrite, decodes the address on request
// ACCESS | channel selected, waiting for the selected slave's ack or timeout
// DONE   | Ready pulse, read data valid on DataOut
// ERR    | Ready + BusErr pulse, ErrAddr/ErrCount updated
module mmio_bus_controller #(
    parameter int N_CH           = 4,
    parameter int ADDR_LENGTH    = 32,
    parameter int DATA_LENGTH    = 32,
    parameter logic [N_CH*ADDR_LENGTH-1:0] CH_BASE =
        {32'h1003_0000, 32'h1002_0000, 32'h0040_0000, 32'h1001_0000},
    parameter logic [N_CH*ADDR_LENGTH-1:0] CH_MASK =
        {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFFF_F000},
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        MemRead,
    input  logic                        MemWrite,
    input  logic [ADDR_LENGTH-1:0]      AddrIn,
    input  logic [DATA_LENGTH-1:0]      DataIn,
    output logic [DATA_LENGTH-1:0]      DataOut,
    output logic                        Ready,
    output logic                        BusErr,
    output logic [ADDR_LENGTH-1:0]      ErrAddr,
    output logic [7:0]                  ErrCount,
    output logic [ADDR_LENGTH-1:0]      AddrOut,
    output logic [DATA_LENGTH-1:0]      DataOutCh,
    output logic                        WriteCh,
    output logic [N_CH-1:0]             Select,
    input  logic [N_CH*DATA_LENGTH-1:0] DataInCh,
    input  logic [N_CH-1:0]             AckCh
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       tmo_cnt;
    logic [CNT_W-1:0]       tmo_nxt;
    logic                   tmo_hit;
    logic [ADDR_LENGTH-1:0] addr_full;
    logic [N_CH-1:0]        hit_vec;
    logic                   hit_found;
    logic [ADDR_LENGTH-1:0] hit_offset;
    logic [DATA_LENGTH-1:0] rd_mux;
    logic                   ack_sel;
    logic [7:0]             err_cnt_nxt;

    // Lowest matching index wins when windows overlap.
    always_comb begin
        hit_vec    = '0;
        hit_found  = 1'b0;
        hit_offset = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!hit_found &&
                ((AddrIn & CH_MASK[ADDR_LENGTH*i +: ADDR_LENGTH]) ==
                 CH_BASE[ADDR_LENGTH*i +: ADDR_LENGTH])) begin
                hit_vec[i] = 1'b1;
                hit_found  = 1'b1;
                hit_offset = AddrIn & ~CH_MASK[ADDR_LENGTH*i +: ADDR_LENGTH];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (Select[i]) begin
                rd_mux = rd_mux | DataInCh[DATA_LENGTH*i +: DATA_LENGTH];
            end
        end
    end

    assign ack_sel     = |(AckCh & Select);
    assign tmo_nxt     = tmo_cnt + 1'b1;
    assign tmo_hit     = (TIMEOUT_CYCLES > 0) && (tmo_nxt == TMO_LIM);
    assign err_cnt_nxt = (ErrCount == 8'hFF) ? ErrCount : ErrCount + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            addr_full <= '0;
            DataOut   <= '0;
            Ready     <= 1'b0;
            BusErr    <= 1'b0;
            ErrAddr   <= '0;
            ErrCount  <= '0;
            AddrOut   <= '0;
            DataOutCh <= '0;
            WriteCh   <= 1'b0;
            Select    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Ready  <= 1'b0;
                    BusErr <= 1'b0;
                    if (MemRead || MemWrite) begin
                        addr_full <= AddrIn;
                        if (hit_found) begin
                            Select    <= hit_vec;
                            AddrOut   <= hit_offset;
                            DataOutCh <= DataIn;
                            WriteCh   <= MemWrite;
                            tmo_cnt   <= '0;
                            state     <= ACCESS;
                        end else begin
                            Ready    <= 1'b1;
                            BusErr   <= 1'b1;
                            DataOut  <= '0;
                            ErrAddr  <= AddrIn;
                            ErrCount <= err_cnt_nxt;
                            state    <= ERR;
                        end
                    end
                end
                ACCESS: begin
                    // An ack in the final allowed cycle beats the timeout.
                    if (ack_sel) begin
                        DataOut <= WriteCh ? '0 : rd_mux;
                        Select  <= '0;
                        WriteCh <= 1'b0;
                        Ready   <= 1'b1;
                        state   <= DONE;
                    end else if (tmo_hit) begin
                        DataOut  <= '0;
                        Select   <= '0;
                        WriteCh  <= 1'b0;
                        Ready    <= 1'b1;
                        BusErr   <= 1'b1;
                        ErrAddr  <= addr_full;
                        ErrCount <= err_cnt_nxt;
                        state    <= ERR;
                    end else begin
                        tmo_cnt <= tmo_nxt;
                    end
                end
                DONE, ERR: begin
                    Ready  <= 1'b0;
                    BusErr <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus_controller.sv
// Directed plus randomized transactions against a cycle-level transaction model
// of the MMIO controller's decode, latency, error and saturation rules.
module tb_mmio_bus_controller;

    localparam int TMO = 15;
    localparam logic [31:0] BASE [4] = '{32'h1001_0000, 32'h0040_0000, 32'h1002_0000, 32'h1003_0000};
    localparam logic [31:0] MASK [4] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FFF0, 32'hFFFF_FFF0};

    logic         clk;
    logic         rst;
    logic         MemRead;
    logic         MemWrite;
    logic [31:0]  AddrIn;
    logic [31:0]  DataIn;
    logic [31:0]  DataOut;
    logic         Ready;
    logic         BusErr;
    logic [31:0]  ErrAddr;
    logic [7:0]   ErrCount;
    logic [31:0]  AddrOut;
    logic [31:0]  DataOutCh;
    logic         WriteCh;
    logic [3:0]   Select;
    logic [127:0] DataInCh;
    logic [3:0]   AckCh;

    int checks = 0;
    int errors = 0;

    int          m_errcnt  = 0;
    logic [31:0] m_erraddr = '0;
    logic [31:0] m_dout    = '0;
    logic [31:0] slave_data [4];

    mmio_bus_controller #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .AddrIn(AddrIn), .DataIn(DataIn), .DataOut(DataOut), .Ready(Ready),
        .BusErr(BusErr), .ErrAddr(ErrAddr), .ErrCount(ErrCount), .AddrOut(AddrOut),
        .DataOutCh(DataOutCh), .WriteCh(WriteCh), .Select(Select),
        .DataInCh(DataInCh), .AckCh(AckCh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction: ack_k is the ACCESS cycle in which the slave acks (0 = never).
    task automatic run_txn(input logic [31:0] addr, input logic rd, input logic wr,
                           input logic [31:0] wdata, input int ack_k, input logic [3:0] stray);
        int ch;
        int exp_c;
        logic exp_err;
        logic [3:0] exp_sel;
        ch = -1;
        for (int i = 0; i < 4; i++)
            if (ch < 0 && (addr & MASK[i]) == BASE[i]) ch = i;
        if (ch < 0) begin
            exp_c = 1; exp_err = 1'b1;
        end else if (ack_k >= 1 && ack_k <= TMO) begin
            exp_c = ack_k + 1; exp_err = 1'b0;
        end else begin
            exp_c = TMO + 1; exp_err = 1'b1;
        end
        exp_sel = (ch >= 0) ? 4'(1 << ch) : 4'b0;
        for (int i = 0; i < 4; i++) begin
            slave_data[i] = $urandom;
            DataInCh[32*i +: 32] = slave_data[i];
        end
        MemRead = rd; MemWrite = wr; AddrIn = addr; DataIn = wdata; AckCh = stray;
        @(posedge clk); #1;
        for (int c = 1; c <= exp_c; c++) begin
            if (c < exp_c) begin
                chk("ready_low", Ready, 0);
                chk("select", Select, exp_sel);
                chk("addr_out", AddrOut, addr & ~MASK[ch]);
                chk("data_out_ch", DataOutCh, wdata);
                chk("write_ch", WriteCh, wr);
                AckCh = stray | ((c == ack_k) ? exp_sel : 4'b0);
                @(posedge clk); #1;
            end else begin
                if (exp_err) begin
                    if (m_errcnt < 255) m_errcnt++;
                    m_erraddr = addr;
                    m_dout = '0;
                end else begin
                    m_dout = wr ? 32'h0 : slave_data[ch];
                end
                chk("ready", Ready, 1);
                chk("bus_err", BusErr, exp_err);
                chk("data_out", DataOut, m_dout);
                chk("err_addr", ErrAddr, m_erraddr);
                chk("err_count", ErrCount, m_errcnt);
                chk("select_done", Select, 0);
                chk("write_ch_done", WriteCh, 0);
                AckCh = stray;
            end
        end
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; AckCh = 4'b0;
        chk("ready_pulse", Ready, 0);
        chk("bus_err_pulse", BusErr, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        int sel;
        int mode;
        rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; AddrIn = '0; DataIn = '0;
        DataInCh = '0; AckCh = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", Ready, 0);
        chk("rst_select", Select, 0);
        chk("rst_data_out", DataOut, 0);
        chk("rst_err_count", ErrCount, 0);
        chk("rst_err_addr", ErrAddr, 0);

        run_txn(32'h0040_0008, 1'b1, 1'b0, 32'h0, 1, 4'b0);
        run_txn(32'h1002_0004, 1'b0, 1'b1, 32'h55, 4, 4'b0);
        run_txn(32'h2000_0000, 1'b1, 1'b0, 32'h0, 1, 4'b0);
        run_txn(32'h1001_0000, 1'b1, 1'b1, 32'hA5A5_0001, 2, 4'b1000);
        run_txn(32'h1003_000C, 1'b1, 1'b0, 32'h0, TMO, 4'b0);
        run_txn(32'h1003_0000, 1'b1, 1'b0, 32'h0, 0, 4'b0);
        run_txn(32'h0040_0FFC, 1'b1, 1'b0, 32'h0, 3, 4'b0100);

        for (int n = 0; n < 40; n++) begin
            sel  = $urandom_range(0, 4);
            mode = $urandom_range(0, 2);
            if (sel == 4) a = 32'h2000_0000 | ($urandom & 32'hFFFF);
            else          a = BASE[sel] | ($urandom & ~MASK[sel]);
            run_txn(a, mode != 1, mode != 0, $urandom, $urandom_range(0, 17), 4'b0);
        end

        for (int n = 0; n < 300; n++)
            run_txn(32'h1003_0004, 1'b1, 1'b0, 32'h0, 0, 4'b0);
        chk("err_count_sat", ErrCount, 255);

        run_txn(32'h0040_0010, 1'b1, 1'b0, 32'h0, 1, 4'b0);
        MemRead = 1'b1; AddrIn = 32'h0040_0020; AckCh = 4'b0;
        @(posedge clk); #1;
        chk("pre_rst_select", Select, 4'b0010);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        m_errcnt = 0; m_erraddr = '0; m_dout = '0;
        chk("arst_select", Select, 0);
        chk("arst_write_ch", WriteCh, 0);
        chk("arst_ready", Ready, 0);
        chk("arst_bus_err", BusErr, 0);
        chk("arst_data_out", DataOut, 0);
        chk("arst_addr_out", AddrOut, 0);
        chk("arst_data_out_ch", DataOutCh, 0);
        chk("arst_err_addr", ErrAddr, 0);
        chk("arst_err_count", ErrCount, 0);
        MemRead = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        run_txn(32'h0040_0004, 1'b1, 1'b0, 32'h0, 2, 4'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
